sdc_cmd_seq: RTL and testbench

- Hardware command sequencer for the SD card controller's register slave port.
- Accepts one SD command request (argument, command word, response length) and performs the full register transaction: write argument, write command, wait for the cmd interrupt, read and clear event status, read response words.
- Sits between a hardware requester (boot loader / DMA scheduler) and the controller's slave bus, so SD commands can be issued without CPU polling.

---
 rtl/sdc_seq_pkg.sv | 31 +++
 rtl/sdc_seq_bus_if.sv | 56 +++++
 rtl/sdc_cmd_seq.sv | 213 +++++++++++++++++++++
 tb/tb_sdc_cmd_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdc_seq_pkg.sv
// Shared encodings for the SD command sequencer: FSM states, response-length
// selectors and command event status bit positions.
package sdc_seq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_ARG   = 3'd1;
    localparam logic [2:0] ST_WR_CMD   = 3'd2;
    localparam logic [2:0] ST_WAIT_EVT = 3'd3;
    localparam logic [2:0] ST_RD_EVT   = 3'd4;
    localparam logic [2:0] ST_CLR_EVT  = 3'd5;
    localparam logic [2:0] ST_RD_RESP  = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_ONE  = 2'd1;
    localparam logic [1:0] RESP_FOUR = 2'd2;
    localparam logic [1:0] RESP_RSVD = 2'd3;

    localparam int EVT_CC = 0;

    // Reserved selector 3 behaves like a one-word response.
    function automatic logic [1:0] resp_last_idx(input logic [1:0] sel);
        return (sel == RESP_FOUR) ? 2'd3 : 2'd0;
    endfunction

    // A clean completion is command-complete alone with no error flags.
    function automatic logic evt_is_error(input logic [15:0] evt);
        return !evt[EVT_CC] || (evt[15:1] != 15'd0);
    endfunction

endpackage

// File: rtl/sdc_seq_bus_if.sv
// Single-access Avalon-MM master: holds one access stable until ack and
// guarantees an idle chipselect cycle between consecutive accesses.
module sdc_seq_bus_if (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic [7:0]  m_address_o,
    output logic [31:0] m_writedata_o,
    output logic        m_write_o,
    output logic        m_read_o,
    output logic        m_chipselect_o,
    input  logic [31:0] m_readdata_i,
    input  logic        m_ack_i
);

    logic        cs_q;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;

    // A start is only accepted with chipselect low, so the cycle after an
    // ack always idles the bus before the next access can begin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 32'h0;
        end else if (cs_q) begin
            if (m_ack_i) begin
                cs_q <= 1'b0;
            end
        end else if (start_i) begin
            cs_q    <= 1'b1;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    assign busy_o         = cs_q;
    assign done_o         = cs_q & m_ack_i;
    assign rdata_o        = m_readdata_i;
    assign m_chipselect_o = cs_q;
    assign m_write_o      = cs_q & we_q;
    assign m_read_o       = cs_q & ~we_q;
    assign m_address_o    = cs_q ? addr_q : 8'h00;
    assign m_writedata_o  = (cs_q & we_q) ? wdata_q : 32'h0;

endmodule

// File: rtl/sdc_cmd_seq.sv
// SD command sequencer: runs the argument/command/event/response register
// transaction on the controller slave port for one hardware request.
module sdc_cmd_seq
    import sdc_seq_pkg::*;
#(
    parameter logic [7:0]  ARG_ADDR       = 8'h00,
    parameter logic [7:0]  CMD_ADDR       = 8'h04,
    parameter logic [7:0]  RESP0_ADDR     = 8'h08,
    parameter logic [7:0]  EVT_ADDR       = 8'h30,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [31:0]  req_arg_i,
    input  logic [31:0]  req_cmd_i,
    input  logic [1:0]   req_resp_sel_i,
    input  logic         abort_i,
    output logic         done_o,
    output logic         err_o,
    output logic         timeout_o,
    output logic [15:0]  evt_status_o,
    output logic [127:0] resp_o,
    output logic         busy_o,
    output logic [7:0]   m_address_o,
    output logic [31:0]  m_writedata_o,
    input  logic [31:0]  m_readdata_i,
    output logic [3:0]   m_byteenable_o,
    output logic         m_write_o,
    output logic         m_read_o,
    output logic         m_chipselect_o,
    input  logic         m_ack_i,
    input  logic         int_cmd_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT_CYCLES);

    logic [2:0]    state_q, state_d;
    logic [31:0]   arg_q, arg_d;
    logic [31:0]   cmd_q, cmd_d;
    logic [1:0]    sel_q, sel_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic [15:0]   evt_q, evt_d;
    logic [127:0]  resp_q, resp_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          bus_start, bus_we, bus_busy, bus_done;
    logic [7:0]    bus_addr;
    logic [31:0]   bus_wdata, bus_rdata;
    logic          access_state;

    assign access_state = (state_q == ST_WR_ARG)  || (state_q == ST_WR_CMD) ||
                          (state_q == ST_RD_EVT)  || (state_q == ST_CLR_EVT) ||
                          (state_q == ST_RD_RESP);
    assign bus_start    = access_state && !bus_busy;

    always_comb begin
        bus_we    = 1'b1;
        bus_addr  = ARG_ADDR;
        bus_wdata = arg_q;
        case (state_q)
            ST_WR_CMD: begin
                bus_addr  = CMD_ADDR;
                bus_wdata = cmd_q;
            end
            ST_RD_EVT: begin
                bus_we    = 1'b0;
                bus_addr  = EVT_ADDR;
                bus_wdata = 32'h0;
            end
            ST_CLR_EVT: begin
                bus_addr  = EVT_ADDR;
                bus_wdata = 32'h0;
            end
            ST_RD_RESP: begin
                bus_we    = 1'b0;
                bus_addr  = RESP0_ADDR + {4'b0000, idx_q, 2'b00};
                bus_wdata = 32'h0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        arg_d   = arg_q;
        cmd_d   = cmd_q;
        sel_d   = sel_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        evt_d   = evt_q;
        resp_d  = resp_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    arg_d   = req_arg_i;
                    cmd_d   = req_cmd_i;
                    sel_d   = req_resp_sel_i;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    evt_d   = 16'h0;
                    resp_d  = 128'h0;
                    state_d = ST_WR_ARG;
                end
            end
            ST_WR_ARG: if (bus_done) state_d = ST_WR_CMD;
            ST_WR_CMD: begin
                if (bus_done) begin
                    timer_d = '0;
                    state_d = ST_WAIT_EVT;
                end
            end
            ST_WAIT_EVT: begin
                // Interrupt wins over abort and timeout in the same cycle.
                if (int_cmd_i) begin
                    state_d = ST_RD_EVT;
                end else if (abort_i) begin
                    err_d   = 1'b1;
                    state_d = ST_CLR_EVT;
                end else if (timer_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_CLR_EVT;
                end else if (timer_q != TMO_SAT) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RD_EVT: begin
                if (bus_done) begin
                    evt_d = bus_rdata[15:0];
                    if (evt_is_error(bus_rdata[15:0])) err_d = 1'b1;
                    state_d = ST_CLR_EVT;
                end
            end
            ST_CLR_EVT: begin
                if (bus_done) begin
                    idx_d   = 2'd0;
                    state_d = (err_q || sel_q == RESP_NONE) ? ST_DONE : ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (bus_done) begin
                    resp_d[{idx_q, 5'd0} +: 32] = bus_rdata;
                    if (idx_q == resp_last_idx(sel_q)) state_d = ST_DONE;
                    else                               idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            arg_q   <= 32'h0;
            cmd_q   <= 32'h0;
            sel_q   <= RESP_NONE;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            evt_q   <= 16'h0;
            resp_q  <= 128'h0;
            idx_q   <= 2'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            cmd_q   <= cmd_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            evt_q   <= evt_d;
            resp_q  <= resp_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    sdc_seq_bus_if u_bus (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (bus_start),
        .we_i           (bus_we),
        .addr_i         (bus_addr),
        .wdata_i        (bus_wdata),
        .busy_o         (bus_busy),
        .done_o         (bus_done),
        .rdata_o        (bus_rdata),
        .m_address_o    (m_address_o),
        .m_writedata_o  (m_writedata_o),
        .m_write_o      (m_write_o),
        .m_read_o       (m_read_o),
        .m_chipselect_o (m_chipselect_o),
        .m_readdata_i   (m_readdata_i),
        .m_ack_i        (m_ack_i)
    );

    assign req_ready_o    = (state_q == ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);
    assign err_o          = err_q;
    assign timeout_o      = tmo_q;
    assign evt_status_o   = evt_q;
    assign resp_o         = resp_q;
    assign m_byteenable_o = 4'hF;

endmodule

// File: tb/tb_sdc_cmd_seq.sv
// Bench for sdc_cmd_seq: a bus slave with configurable ack delay and cmd
// interrupt/abort timing, checked against a transaction-level reference model.
module tb_sdc_cmd_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_arg = 32'h0;
    logic [31:0]  req_cmd = 32'h0;
    logic [1:0]   req_sel = 2'd0;
    logic         abort = 1'b0;
    logic         done, err, tmo, busy;
    logic [15:0]  evt_status;
    logic [127:0] resp;
    logic [7:0]   m_address;
    logic [31:0]  m_writedata;
    logic [31:0]  m_readdata = 32'h0;
    logic [3:0]   m_byteenable;
    logic         m_write, m_read, m_cs;
    logic         m_ack = 1'b0;
    logic         int_cmd = 1'b0;

    always #5 clk = ~clk;

    sdc_cmd_seq #(.TIMEOUT_CYCLES(100)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_arg_i      (req_arg),
        .req_cmd_i      (req_cmd),
        .req_resp_sel_i (req_sel),
        .abort_i        (abort),
        .done_o         (done),
        .err_o          (err),
        .timeout_o      (tmo),
        .evt_status_o   (evt_status),
        .resp_o         (resp),
        .busy_o         (busy),
        .m_address_o    (m_address),
        .m_writedata_o  (m_writedata),
        .m_readdata_i   (m_readdata),
        .m_byteenable_o (m_byteenable),
        .m_write_o      (m_write),
        .m_read_o       (m_read),
        .m_chipselect_o (m_cs),
        .m_ack_i        (m_ack),
        .int_cmd_i      (int_cmd)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- bus slave / interrupt / abort environment ----------------
    int          ack_dly = 0;
    logic [31:0] evt_rd = 32'h1;
    logic [31:0] resp_rd [4];
    bit          int_pre = 0, int_arm = 0, abort_arm = 0, abort_early = 0;
    int          int_dly = 0, abort_dly = 0;
    bit          int_lat = 0;
    int          int_cnt = -1, abort_cnt = -1;
    int          cnt = 0;
    int          stab_err = 0, gap_err = 0;
    logic [40:0] cur = '0, obs_acc;
    logic [7:0]  acc_a;
    logic [40:0] trace_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ack = 1'b0; cnt = 0; int_lat = 0; int_cnt = -1; abort_cnt = -1;
            abort = 1'b0; int_cmd = int_pre;
        end else begin
            abort = 1'b0;
            if (m_ack) begin
                m_ack = 1'b0; cnt = 0;
                if (m_cs) gap_err++;
                trace_q.push_back(cur);
                if (cur[40] && cur[39:32] == 8'h04) begin
                    if (int_arm)   int_cnt   = int_dly;
                    if (abort_arm) abort_cnt = abort_dly;
                end
                if (cur[40] && cur[39:32] == 8'h30) int_lat = 0;
            end else if (m_cs) begin
                obs_acc = {m_write, m_address, m_writedata};
                if (cnt == 0) cur = obs_acc;
                else if (obs_acc !== cur) stab_err++;
                if (m_write == m_read) stab_err++;
                if (abort_early && m_address == 8'h00) abort = 1'b1;
                if (cnt == ack_dly) m_ack = 1'b1;
                cnt++;
            end
            acc_a = cur[39:32];
            if (!m_ack)               m_readdata = $urandom;
            else if (acc_a == 8'h30)  m_readdata = evt_rd;
            else if (acc_a >= 8'h08 && acc_a <= 8'h14) m_readdata = resp_rd[(int'(acc_a) - 8) / 4];
            else                      m_readdata = $urandom;
            if (int_cnt == 0) int_lat = 1;
            if (int_cnt >= 0) int_cnt--;
            if (abort_cnt == 0) abort = 1'b1;
            if (abort_cnt >= 0) abort_cnt--;
            int_cmd = int_pre | int_lat;
        end
    end

    // ---------------- reference model: expected transaction outcome ----------------
    localparam int K_INT = 0, K_TMO = 1, K_ABORT = 2;
    logic [40:0]  exp_q[$];
    logic         e_err, e_tmo;
    logic [15:0]  e_evt;
    logic [127:0] e_resp;

    task automatic build_expect(input int kind, input logic [31:0] arg, input logic [31:0] cmd,
                                input logic [1:0] sel);
        int nwords;
        exp_q.delete();
        exp_q.push_back({1'b1, 8'h00, arg});
        exp_q.push_back({1'b1, 8'h04, cmd});
        e_err = 0; e_tmo = 0; e_evt = 16'h0; e_resp = '0;
        if (kind == K_INT) begin
            exp_q.push_back({1'b0, 8'h30, 32'h0});
            e_evt = evt_rd[15:0];
            e_err = (e_evt != 16'h0001);
        end else begin
            e_err = 1;
            e_tmo = (kind == K_TMO);
        end
        exp_q.push_back({1'b1, 8'h30, 32'h0});
        nwords = (e_err || sel == 2'd0) ? 0 : (sel == 2'd2 ? 4 : 1);
        for (int k = 0; k < nwords; k++) begin
            exp_q.push_back({1'b0, 8'(8 + 4 * k), 32'h0});
            e_resp[32 * k +: 32] = resp_rd[k];
        end
    endtask

    task automatic run_txn(input string tag, input int kind, input logic [31:0] arg,
                           input logic [31:0] cmd, input logic [1:0] sel, output int lat);
        bit seen;
        int n;
        logic [40:0] a, e;
        build_expect(kind, arg, cmd, sel);
        @(negedge clk);
        trace_q.delete();
        chk({tag, ".ready"}, 128'(req_ready), 128'(1'b1));
        req_arg = arg; req_cmd = cmd; req_sel = sel; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; seen = 0;
        while (!seen && lat < 3000) begin
            @(posedge clk);
            lat++;
            #1 if (done) seen = 1;
        end
        chk({tag, ".done"}, 128'(seen), 128'(1'b1));
        chk({tag, ".err"}, 128'(err), 128'(e_err));
        chk({tag, ".timeout"}, 128'(tmo), 128'(e_tmo));
        chk({tag, ".evt"}, 128'(evt_status), 128'(e_evt));
        chk({tag, ".resp"}, resp, e_resp);
        chk({tag, ".busy_at_done"}, 128'(busy), 128'(1'b1));
        @(posedge clk);
        #1;
        chk({tag, ".done_1cyc"}, 128'({done, req_ready, err}), 128'({1'b0, 1'b1, e_err}));
        chk({tag, ".trace_len"}, 128'(trace_q.size()), 128'(exp_q.size()));
        n = (trace_q.size() < exp_q.size()) ? trace_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            a = trace_q[i];
            e = exp_q[i];
            if (!e[40]) a[31:0] = 32'h0;
            chk($sformatf("%s.bus%0d", tag, i), 128'(a), 128'(e));
        end
    endtask

    initial begin
        int lat, r, kind, n;
        bit found, dseen;
        for (int k = 0; k < 4; k++) resp_rd[k] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready_busy_done", 128'({req_ready, busy, done}), 128'(3'b100));
        chk("rst.bus", 128'({m_cs, m_write, m_read, m_address, m_writedata}), 128'(0));
        chk("rst.status", {err, tmo, evt_status, resp[109:0]}, 128'(0));
        chk("rst.byteen", 128'(m_byteenable), 128'(4'hF));
        @(negedge clk) rst_n = 1'b1;

        // Minimum latency: zero-wait ack, interrupt already pending, no response
        ack_dly = 0; int_pre = 1; evt_rd = 32'h1;
        run_txn("lat", K_INT, 32'h0, 32'h0, 2'd0, lat);
        chk("lat.cycles", 128'(lat), 128'(9));
        int_pre = 0;

        // One-word response, ack after 2 cycles, interrupt 50 cycles after cmd
        ack_dly = 2; int_arm = 1; int_dly = 50; evt_rd = 32'h1; resp_rd[0] = 32'h1AA;
        run_txn("r1", K_INT, 32'h1AA, 32'h0819, 2'd1, lat);

        // Four-word response
        resp_rd[0] = 32'hA; resp_rd[1] = 32'hB; resp_rd[2] = 32'hC; resp_rd[3] = 32'hD;
        int_dly = 3;
        run_txn("r4", K_INT, 32'h12345678, 32'h0229, 2'd2, lat);

        // Timeout: no interrupt ever
        int_arm = 0;
        run_txn("tmo", K_TMO, 32'h0, 32'h0000, 2'd2, lat);

        // Event error flags suppress the response read
        int_arm = 1; int_dly = 5; evt_rd = 32'hBEEF0003;
        run_txn("evterr", K_INT, 32'h55, 32'h0811, 2'd1, lat);

        // Abort in WAIT_EVT; an abort during the argument write is ignored
        int_arm = 0; abort_arm = 1; abort_dly = 7; abort_early = 1; evt_rd = 32'h1;
        run_txn("abort", K_ABORT, 32'h77, 32'h0C00, 2'd1, lat);
        abort_early = 0;

        // Interrupt and abort in the same cycle: interrupt wins
        int_arm = 1; int_dly = 4; abort_dly = 4;
        run_txn("prio", K_INT, 32'h99, 32'h0A0A, 2'd3, lat);
        abort_arm = 0;

        // Long wait-states: strobes must stay stable for 20 cycles of ack low
        ack_dly = 20; int_dly = 2;
        run_txn("slow", K_INT, 32'hCAFEF00D, 32'h0D0D, 2'd2, lat);

        // Randomized transactions
        for (int t = 0; t < 10; t++) begin
            ack_dly = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) resp_rd[k] = $urandom;
            r = $urandom_range(0, 9);
            kind = (r < 7) ? K_INT : (r < 9 ? K_ABORT : K_TMO);
            int_arm = (kind == K_INT); int_dly = $urandom_range(0, 40);
            abort_arm = (kind == K_ABORT); abort_dly = $urandom_range(0, 40);
            abort_early = $urandom_range(0, 1);
            evt_rd = ($urandom_range(0, 3) == 0) ? $urandom : {16'($urandom), 16'h0001};
            run_txn($sformatf("rnd%0d", t), kind, $urandom, $urandom, 2'($urandom), lat);
        end
        abort_arm = 0; abort_early = 0;

        // Reset asserted in the middle of the command write
        ack_dly = 20; int_arm = 0;
        @(negedge clk);
        req_arg = 32'h1; req_cmd = 32'h2; req_sel = 2'd1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        found = 0; n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (m_cs && m_address == 8'h04) found = 1;
        end
        chk("mrst.reach_wrcmd", 128'(found), 128'(1'b1));
        #3 rst_n = 1'b0;
        #1;
        chk("mrst.ready_busy_done", 128'({req_ready, busy, done}), 128'(3'b100));
        chk("mrst.bus", 128'({m_cs, m_write, m_read, m_address, m_writedata}), 128'(0));
        chk("mrst.status", {err, tmo, evt_status, resp[109:0]}, 128'(0));
        dseen = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done) dseen = 1;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1 if (done || busy) dseen = 1;
        end
        chk("mrst.no_done", 128'(dseen), 128'(1'b0));

        // Recovery after reset
        ack_dly = 1; int_arm = 1; int_dly = 1; evt_rd = 32'h1; resp_rd[0] = 32'h600D;
        run_txn("recov", K_INT, 32'h3, 32'h4, 2'd1, lat);

        chk("bus.stable", 128'(stab_err), 128'(0));
        chk("bus.gap", 128'(gap_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
